// File: rtl/write_back_pkg.sv
// Shared pipeline definitions for the write-back stage: source encodings,
// the hardwired-zero register number and default bus widths.
package pipeline_defs;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;

    typedef enum logic [1:0] {
        SOURCE_ALU      = 2'd0,
        SOURCE_MEMORY   = 2'd1,
        SOURCE_PC4      = 2'd2,
        SOURCE_RESERVED = 2'd3
    } wb_source_e;

    localparam logic [4:0] REGISTER_ZERO = 5'd0;

endpackage

// File: rtl/write_back_if.sv
// mem_wb_* bus from the memory stage (master) into the write-back stage (slave).
interface write_back_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]    mem_wb_alu_result;
    logic [DATA_WIDTH-1:0]    mem_wb_data;
    logic [DATA_WIDTH-1:0]    mem_wb_pc4;
    logic                     mem_wb_write_register;
    logic [ADDRESS_WIDTH-1:0] mem_wb_register_number;
    logic [1:0]               mem_wb_register_source;

    modport master (
        output mem_wb_alu_result, mem_wb_data, mem_wb_pc4,
        output mem_wb_write_register, mem_wb_register_number, mem_wb_register_source
    );

    modport slave (
        input mem_wb_alu_result, mem_wb_data, mem_wb_pc4,
        input mem_wb_write_register, mem_wb_register_number, mem_wb_register_source
    );
endinterface

// File: rtl/write_back_register_file.sv
// Register file: one synchronous write port with active-low synchronous clear,
// three combinational read ports (a, b, debug); register 0 always reads zero.
module register_file
    import pipeline_defs::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_number,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_number_a,
    input  logic [ADDRESS_WIDTH-1:0] read_number_b,
    input  logic [ADDRESS_WIDTH-1:0] debug_number,
    output logic [DATA_WIDTH-1:0]    read_data_a,
    output logic [DATA_WIDTH-1:0]    read_data_b,
    output logic [DATA_WIDTH-1:0]    debug_data
);

    localparam int                       REGISTER_COUNT = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_NUMBER    = ADDRESS_WIDTH'(REGISTER_ZERO);

    logic [DATA_WIDTH-1:0] r_regs [0:REGISTER_COUNT-1];

    // Array update: clear everything on reset, otherwise commit nonzero writes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write_enable && (write_number != ZERO_NUMBER)) begin
            r_regs[write_number] <= write_data;
        end
    end

    // Read ports with register-0 masking.
    always_comb begin
        read_data_a = '0;
        read_data_b = '0;
        debug_data  = '0;
        if (read_number_a == ZERO_NUMBER) begin
            read_data_a = '0;
        end else begin
            read_data_a = r_regs[read_number_a];
        end
        if (read_number_b == ZERO_NUMBER) begin
            read_data_b = '0;
        end else begin
            read_data_b = r_regs[read_number_b];
        end
        if (debug_number == ZERO_NUMBER) begin
            debug_data = '0;
        end else begin
            debug_data = r_regs[debug_number];
        end
    end

endmodule

// File: rtl/write_back.sv
// Write-back stage: source mux, register-file commit, forwarding info and a
// committed-write counter. Define WB_BYPASS_EN to forward same-cycle writes to read ports.
module write_back
    import pipeline_defs::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    write_back_if.slave              mem_wb,
    input  logic [ADDRESS_WIDTH-1:0] read_number_a,
    input  logic [ADDRESS_WIDTH-1:0] read_number_b,
    output logic [DATA_WIDTH-1:0]    read_data_a,
    output logic [DATA_WIDTH-1:0]    read_data_b,
    output logic                     wb_write_enable,
    output logic [ADDRESS_WIDTH-1:0] wb_register_number,
    output logic [DATA_WIDTH-1:0]    wb_write_data,
    output logic                     wb_last_valid,
    output logic [ADDRESS_WIDTH-1:0] wb_last_number,
    output logic [DATA_WIDTH-1:0]    wb_last_data,
    input  logic [ADDRESS_WIDTH-1:0] debug_number,
    output logic [DATA_WIDTH-1:0]    debug_data,
    output logic [31:0]              write_count
);

    localparam logic [ADDRESS_WIDTH-1:0] ZERO_NUMBER = ADDRESS_WIDTH'(REGISTER_ZERO);

    logic [DATA_WIDTH-1:0]    w_write_data;
    logic                     w_write_enable;
    logic [DATA_WIDTH-1:0]    w_array_a;
    logic [DATA_WIDTH-1:0]    w_array_b;
    logic                     r_last_valid;
    logic [ADDRESS_WIDTH-1:0] r_last_number;
    logic [DATA_WIDTH-1:0]    r_last_data;
    logic [31:0]              r_write_count;

    // Write-back source selection; the reserved code never commits, so its data is don't-care.
    always_comb begin
        w_write_data = mem_wb.mem_wb_alu_result;
        case (mem_wb.mem_wb_register_source)
            SOURCE_ALU:    w_write_data = mem_wb.mem_wb_alu_result;
            SOURCE_MEMORY: w_write_data = mem_wb.mem_wb_data;
            SOURCE_PC4:    w_write_data = mem_wb.mem_wb_pc4;
            default:       w_write_data = mem_wb.mem_wb_alu_result;
        endcase
    end

    assign w_write_enable = reset
                          & mem_wb.mem_wb_write_register
                          & (mem_wb.mem_wb_register_number != ZERO_NUMBER)
                          & (mem_wb.mem_wb_register_source != SOURCE_RESERVED);

    assign wb_write_enable    = w_write_enable;
    assign wb_register_number = mem_wb.mem_wb_register_number;
    assign wb_write_data      = w_write_data;

    register_file #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_register_file (
        .clock        (clock),
        .reset        (reset),
        .write_enable (w_write_enable),
        .write_number (mem_wb.mem_wb_register_number),
        .write_data   (w_write_data),
        .read_number_a(read_number_a),
        .read_number_b(read_number_b),
        .debug_number (debug_number),
        .read_data_a  (w_array_a),
        .read_data_b  (w_array_b),
        .debug_data   (debug_data)
    );

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding; w_write_enable already excludes register 0.
    always_comb begin
        read_data_a = w_array_a;
        read_data_b = w_array_b;
        if (w_write_enable && (read_number_a == mem_wb.mem_wb_register_number)) begin
            read_data_a = w_write_data;
        end else begin
            read_data_a = w_array_a;
        end
        if (w_write_enable && (read_number_b == mem_wb.mem_wb_register_number)) begin
            read_data_b = w_write_data;
        end else begin
            read_data_b = w_array_b;
        end
    end
`else
    assign read_data_a = w_array_a;
    assign read_data_b = w_array_b;
`endif

    // Previous-cycle write info for the hazard unit, plus the committed-write counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last_valid  <= 1'b0;
            r_last_number <= '0;
            r_last_data   <= '0;
            r_write_count <= 32'd0;
        end else begin
            r_last_valid  <= w_write_enable;
            r_last_number <= mem_wb.mem_wb_register_number;
            r_last_data   <= w_write_data;
            if (w_write_enable) begin
                r_write_count <= r_write_count + 32'd1;
            end
        end
    end

    assign wb_last_valid  = r_last_valid;
    assign wb_last_number = r_last_number;
    assign wb_last_data   = r_last_data;
    assign write_count    = r_write_count;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back; expectations follow WB_BYPASS_EN when it is defined.
module tb_write_back;

    logic        clock;
    logic        reset;
    logic [4:0]  read_number_a;
    logic [4:0]  read_number_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic        wb_write_enable;
    logic [4:0]  wb_register_number;
    logic [31:0] wb_write_data;
    logic        wb_last_valid;
    logic [4:0]  wb_last_number;
    logic [31:0] wb_last_data;
    logic [4:0]  debug_number;
    logic [31:0] debug_data;
    logic [31:0] write_count;

    int n_vec = 0;
    int n_err = 0;

    write_back_if mem_wb_bus ();

    write_back dut (
        .clock             (clock),
        .reset             (reset),
        .mem_wb            (mem_wb_bus.slave),
        .read_number_a     (read_number_a),
        .read_number_b     (read_number_b),
        .read_data_a       (read_data_a),
        .read_data_b       (read_data_b),
        .wb_write_enable   (wb_write_enable),
        .wb_register_number(wb_register_number),
        .wb_write_data     (wb_write_data),
        .wb_last_valid     (wb_last_valid),
        .wb_last_number    (wb_last_number),
        .wb_last_data      (wb_last_data),
        .debug_number      (debug_number),
        .debug_data        (debug_data),
        .write_count       (write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] num, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4);
        mem_wb_bus.mem_wb_write_register  = we;
        mem_wb_bus.mem_wb_register_number = num;
        mem_wb_bus.mem_wb_register_source = src;
        mem_wb_bus.mem_wb_alu_result      = alu;
        mem_wb_bus.mem_wb_data            = mem;
        mem_wb_bus.mem_wb_pc4             = pc4;
        #1;
    endtask

    task automatic idle();
        mem_wb_bus.mem_wb_write_register = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_same_cycle;

        reset         = 1'b0;
        read_number_a = 5'd0;
        read_number_b = 5'd0;
        debug_number  = 5'd0;
        drive(1'b1, 5'd4, 2'd0, 32'h0000_1111, 32'h0, 32'h0);
        check("enable_low_in_reset", {31'd0, wb_write_enable}, 32'd0);
        tick();
        tick();
        read_number_a = 5'd4;
        debug_number  = 5'd4;
        idle();
        check("init_count", write_count, 32'd0);
        check("init_last_valid", {31'd0, wb_last_valid}, 32'd0);
        check("init_read_a", read_data_a, 32'd0);
        check("init_debug", debug_data, 32'd0);

        // Writes followed by a reset edge that also carries an in-flight write.
        reset = 1'b1;
        drive(1'b1, 5'd3, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
        tick();
        drive(1'b1, 5'd7, 2'd1, 32'h0, 32'h0BAD_F00D, 32'h0);
        tick();
        read_number_a = 5'd3;
        read_number_b = 5'd7;
        debug_number  = 5'd9;
        drive(1'b1, 5'd9, 2'd0, 32'h1111_2222, 32'h0, 32'h0);
        check("pre_reset_count", write_count, 32'd2);
        check("pre_reset_read_a", read_data_a, 32'hAAAA_5555);
        check("pre_reset_read_b", read_data_b, 32'h0BAD_F00D);
        reset = 1'b0;
        #1;
        check("enable_dropped_by_reset", {31'd0, wb_write_enable}, 32'd0);
        tick();
        reset = 1'b1;
        idle();
        check("post_reset_read_a", read_data_a, 32'd0);
        check("post_reset_read_b", read_data_b, 32'd0);
        check("post_reset_debug", debug_data, 32'd0);
        check("post_reset_last_valid", {31'd0, wb_last_valid}, 32'd0);
        check("post_reset_last_number", {27'd0, wb_last_number}, 32'd0);
        check("post_reset_last_data", wb_last_data, 32'd0);
        check("post_reset_count", write_count, 32'd0);

        // ALU write to register 5.
        read_number_a = 5'd5;
        drive(1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0004);
        check("alu_enable", {31'd0, wb_write_enable}, 32'd1);
        check("alu_number", {27'd0, wb_register_number}, 32'd5);
        check("alu_data", wb_write_data, 32'h1234_5678);
        tick();
        idle();
        check("r5_read_a", read_data_a, 32'h1234_5678);
        check("r5_last_valid", {31'd0, wb_last_valid}, 32'd1);
        check("r5_last_number", {27'd0, wb_last_number}, 32'd5);
        check("r5_last_data", wb_last_data, 32'h1234_5678);
        check("r5_count", write_count, 32'd1);

        // Memory-source write to register 0 is discarded.
        read_number_a = 5'd0;
        debug_number  = 5'd0;
        drive(1'b1, 5'd0, 2'd1, 32'h0, 32'hDEAD_BEEF, 32'h0);
        check("r0_enable", {31'd0, wb_write_enable}, 32'd0);
        check("r0_data_visible", wb_write_data, 32'hDEAD_BEEF);
        tick();
        idle();
        check("r0_read_a", read_data_a, 32'd0);
        check("r0_debug", debug_data, 32'd0);
        check("r0_count", write_count, 32'd1);
        check("r0_last_valid", {31'd0, wb_last_valid}, 32'd0);
        check("r0_last_data", wb_last_data, 32'hDEAD_BEEF);

        // pc4 write to register 31 while both ports and debug read it.
        drive(1'b1, 5'd31, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        tick();
        read_number_a = 5'd31;
        read_number_b = 5'd31;
        debug_number  = 5'd31;
        drive(1'b1, 5'd31, 2'd2, 32'h5555_5555, 32'h6666_6666, 32'h0040_0008);
`ifdef WB_BYPASS_EN
        exp_same_cycle = 32'h0040_0008;
`else
        exp_same_cycle = 32'hCAFE_F00D;
`endif
        check("r31_same_cycle_b", read_data_b, exp_same_cycle);
        check("r31_same_cycle_a", read_data_a, exp_same_cycle);
        check("r31_same_cycle_debug", debug_data, 32'hCAFE_F00D);
        tick();
        idle();
        check("r31_next_b", read_data_b, 32'h0040_0008);
        check("r31_next_a", read_data_a, 32'h0040_0008);
        check("r31_next_debug", debug_data, 32'h0040_0008);
        check("r31_count", write_count, 32'd3);

        // Reserved source never writes.
        read_number_a = 5'd12;
        drive(1'b1, 5'd12, 2'd3, 32'h7777_7777, 32'h0, 32'h0);
        check("reserved_enable", {31'd0, wb_write_enable}, 32'd0);
        tick();
        idle();
        check("reserved_last_valid", {31'd0, wb_last_valid}, 32'd0);
        check("reserved_last_number", {27'd0, wb_last_number}, 32'd12);
        check("reserved_read_a", read_data_a, 32'd0);
        check("reserved_count", write_count, 32'd3);

        // Counter wrap from all ones.
        force dut.r_write_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_write_count;
        #1;
        check("preload_count", write_count, 32'hFFFF_FFFF);
        read_number_a = 5'd2;
        drive(1'b1, 5'd2, 2'd1, 32'h0, 32'h0000_0042, 32'h0);
        tick();
        idle();
        check("wrap_count", write_count, 32'd0);
        check("wrap_read_a", read_data_a, 32'h0000_0042);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/write_back.md
Name: write_back

Overview:
- Write-back stage of the 5-stage pipeline; the consumer of the mem_wb_* bus that the memory stage drives.
- Selects the write-back value (ALU result, loaded data, or pc4 for link instructions) and commits it to the 32-entry register file.
- Serves the decode stage's two read ports and exports current and one-cycle-delayed write info for the forwarding/hazard units.
- Keeps a committed-write counter and a debug read port for the board display.

Parameters:
DATA_WIDTH, 32, width of register and data buses
ADDRESS_WIDTH, 5, register number width (2**ADDRESS_WIDTH registers)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising edge of clock)
mem_wb_alu_result  input  32  ALU result from memory stage
mem_wb_data  input  32  loaded memory data
mem_wb_pc4  input  32  pc+4 of the instruction
mem_wb_write_register  input  1  instruction writes a register
mem_wb_register_number  input  5  destination register
mem_wb_register_source  input  2  write-back source select
read_number_a  input  5  decode read port A address
read_number_b  input  5  decode read port B address
read_data_a  output  32  port A data (combinational)
read_data_b  output  32  port B data (combinational)
wb_write_enable  output  1  register write committing this cycle (combinational)
wb_register_number  output  5  destination of current write
wb_write_data  output  32  value of current write
wb_last_valid  output  1  registered copy of wb_write_enable from previous cycle
wb_last_number  output  5  registered destination of previous cycle
wb_last_data  output  32  registered data of previous cycle
debug_number  input  5  debug read address
debug_data  output  32  debug read data (combinational, never bypassed)
write_count  output  32  number of committed register writes

Behaviour:
- Source select: 0 -> mem_wb_alu_result, 1 -> mem_wb_data, 2 -> mem_wb_pc4, 3 -> reserved; source 3 forces wb_write_enable=0.
- wb_write_enable = reset & mem_wb_write_register & (mem_wb_register_number!=0) & (source!=3).
- wb_register_number and wb_write_data always reflect the current inputs, even when wb_write_enable=0.
- Register 0 reads as 0 on every port; writes to register 0 are discarded.
- Commit: on rising edge with wb_write_enable=1, regs[wb_register_number] <= wb_write_data. Write latency is 1 edge.
- Read ports: combinational from the array; bypass rule is under Optional Feature.
- wb_last_*: on every non-reset edge, wb_last_valid<=wb_write_enable, wb_last_number<=wb_register_number, wb_last_data<=wb_write_data.
- write_count: increments by 1 on each non-reset edge where wb_write_enable=1. Wraps from 0xFFFFFFFF to 0 with no flag.
- Reset (reset==0 at a rising edge):
  - all 32 registers, wb_last_valid/number/data and write_count become 0;
  - any write pending in that cycle is dropped (wb_write_enable is 0 while reset is low);
  - reset mid-stream loses the in-flight write.
  - After the reset edge, read_data_a/b, debug_data and wb_last_* read 0.
- Simultaneous read and write of the same register: governed by WB_BYPASS_EN.
- Port A and port B reading the same register: both return the identical value.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: read_data_a/b return wb_write_data when wb_write_enable=1 and read_number==wb_register_number (nonzero). Decode sees a same-cycle write without stalling.
- Undefined: read ports return the pre-write array value. The hazard unit must stall or forward from wb_last_*.
- debug_data is unaffected in both cases.

Decomposition:
- Shared package (pipeline_defs):
  - SOURCE_ALU=2'd0, SOURCE_MEMORY=2'd1, SOURCE_PC4=2'd2, SOURCE_RESERVED=2'd3;
  - REGISTER_ZERO=5'd0;
  - DATA_WIDTH and ADDRESS_WIDTH defaults.
- One sub-module, register_file: array, one synchronous write port with active-low synchronous clear, three combinational read ports (a, b, debug), zero-register masking.
- write_back keeps source mux, bypass, wb_last_* registers and the counter.

Test Plan:
- Reset low one edge after random writes -> all read ports, debug_data, wb_last_* and write_count read 0.
- Write register 5, source 0, alu_result=0x12345678 -> next cycle read_data_a(5)=0x12345678; wb_last_valid=1, wb_last_number=5, write_count=1.
- Write register 0, source 1, data=0xDEADBEEF -> wb_write_enable=0, register 0 reads 0, write_count unchanged.
- Write register 31, source 2, pc4=0x00400008, while read_number_b=31 -> same cycle: read_data_b=0x00400008 with WB_BYPASS_EN, old value without it. Next cycle 0x00400008 in both builds.
- Source 3 with write_register=1 -> no write; wb_last_valid=0 next cycle.
- Preload write_count to 0xFFFFFFFF (force) then one committed write -> write_count=0.
